// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and helpers for the mul/div controller.
package muldiv_ctrl_pkg;

   localparam int unsigned MULDIV_OP_WD    = 3;
   localparam int unsigned MULDIV_TO_EX_WD = 65;   // {ready, hi, lo}

   localparam logic [MULDIV_OP_WD-1:0] MD_NONE  = 3'd0;
   localparam logic [MULDIV_OP_WD-1:0] MD_DIV   = 3'd1;
   localparam logic [MULDIV_OP_WD-1:0] MD_DIVU  = 3'd2;
   localparam logic [MULDIV_OP_WD-1:0] MD_MULT  = 3'd3;
   localparam logic [MULDIV_OP_WD-1:0] MD_MULTU = 3'd4;
   localparam logic [MULDIV_OP_WD-1:0] MD_MTHI  = 3'd5;
   localparam logic [MULDIV_OP_WD-1:0] MD_MTLO  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIV_ZERO,
      ST_DIV_ON,
      ST_DIV_END,
      ST_MUL_ON,
      ST_MUL_END
   } state_t;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per cycle on unsigned operands.
// A new start always reloads, so an abandoned division needs no explicit abort.
module muldiv_ctrl_div_iter #(
   parameter int unsigned DATA_WD    = 32,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DATA_WD-1:0] dividend,
   input  logic [DATA_WD-1:0] divisor,
   output logic [DATA_WD-1:0] quotient,
   output logic [DATA_WD-1:0] remainder,
   output logic               done
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

   logic [CNT_W-1:0]   cnt;
   logic               running;
   logic [DATA_WD-1:0] dsr;
   logic [DATA_WD:0]   shifted;
   logic [DATA_WD:0]   diff;

   always_comb begin
      shifted = {remainder, quotient[DATA_WD-1]};
      diff    = shifted - {1'b0, dsr};
   end

   assign done = running && (cnt == CNT_W'(DIV_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         dsr       <= '0;
         cnt       <= '0;
         running   <= 1'b0;
      end else if (start) begin
         quotient  <= dividend;
         remainder <= '0;
         dsr       <= divisor;
         cnt       <= '0;
         running   <= 1'b1;
      end else if (running) begin
         // diff MSB set means the trial subtraction went negative: restore
         if (!diff[DATA_WD]) begin
            remainder <= diff[DATA_WD-1:0];
            quotient  <= {quotient[DATA_WD-2:0], 1'b1};
         end else begin
            remainder <= shifted[DATA_WD-1:0];
            quotient  <= {quotient[DATA_WD-2:0], 1'b0};
         end
         cnt <= cnt + CNT_W'(1);
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div sequencer owning HI/LO. Define MULT_ITER_EN for the iterative
// shift-add multiplier; otherwise MULT/MULTU complete in a single cycle.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned DATA_WD    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MULDIV_OP_WD-1:0] op,
   input  logic [DATA_WD-1:0]      src1,
   input  logic [DATA_WD-1:0]      src2,
   input  logic                    annul,
   output logic                    stallreq,
   output logic                    ready,
   output logic [DATA_WD-1:0]      hi,
   output logic [DATA_WD-1:0]      lo,
   output logic                    busy
);

   state_t             state;
   logic               is_div, signed_op, long_op, div_go;
   logic               sign1, sign2;
   logic [DATA_WD-1:0] abs1, abs2;
   logic [DATA_WD-1:0] div_q, div_r;
   logic               div_done;
   logic               neg_q, neg_r, div_by_zero;

`ifdef MULT_ITER_EN
   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
   logic [2*DATA_WD-1:0] mcand, prod;
   logic [DATA_WD-1:0]   mplier;
   logic [CNT_W-1:0]     mcnt;
   logic                 neg_p;
`else
   logic [2*DATA_WD-1:0] ext1, ext2, mul_full;
`endif

   always_comb begin
      is_div    = (op == MD_DIV) || (op == MD_DIVU);
      signed_op = (op == MD_DIV) || (op == MD_MULT);
      sign1     = signed_op && src1[DATA_WD-1];
      sign2     = signed_op && src2[DATA_WD-1];
      abs1      = sign1 ? (~src1 + 1'b1) : src1;
      abs2      = sign2 ? (~src2 + 1'b1) : src2;
`ifdef MULT_ITER_EN
      long_op   = is_div || (op == MD_MULT) || (op == MD_MULTU);
`else
      long_op   = is_div;
      // Extending to full width first makes one unsigned multiply serve both signednesses
      ext1      = {{DATA_WD{sign1}}, src1};
      ext2      = {{DATA_WD{sign2}}, src2};
      mul_full  = ext1 * ext2;
`endif
      div_go    = (state == ST_IDLE) && start && !annul && is_div && (src2 != '0);
      stallreq  = (state == ST_DIV_ZERO) || (state == ST_DIV_ON) || (state == ST_MUL_ON) ||
                  ((state == ST_IDLE) && start && long_op);
   end

   assign busy = (state != ST_IDLE);

   muldiv_ctrl_div_iter #(
      .DATA_WD    (DATA_WD),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_go),
      .dividend  (abs1),
      .divisor   (abs2),
      .quotient  (div_q),
      .remainder (div_r),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         hi          <= '0;
         lo          <= '0;
         ready       <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef MULT_ITER_EN
         mcand       <= '0;
         prod        <= '0;
         mplier      <= '0;
         mcnt        <= '0;
         neg_p       <= 1'b0;
`endif
      end else begin
         ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !annul) begin
                  case (op)
                     MD_DIV, MD_DIVU: begin
                        neg_q       <= sign1 ^ sign2;
                        neg_r       <= sign1;
                        div_by_zero <= (src2 == '0);
                        state       <= (src2 == '0) ? ST_DIV_ZERO : ST_DIV_ON;
                     end
                     MD_MTHI: begin
                        hi    <= src1;
                        ready <= 1'b1;
                     end
                     MD_MTLO: begin
                        lo    <= src1;
                        ready <= 1'b1;
                     end
                     MD_MULT, MD_MULTU: begin
`ifdef MULT_ITER_EN
                        mcand  <= {{DATA_WD{1'b0}}, abs1};
                        mplier <= abs2;
                        prod   <= '0;
                        mcnt   <= '0;
                        neg_p  <= sign1 ^ sign2;
                        state  <= ST_MUL_ON;
`else
                        {hi, lo} <= mul_full;
                        ready    <= 1'b1;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            ST_DIV_ZERO: begin
               if (annul) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_DIV_END;
                  ready <= 1'b1;
               end
            end
            ST_DIV_ON: begin
               if (annul) begin
                  state <= ST_IDLE;
               end else if (div_done) begin
                  state <= ST_DIV_END;
                  ready <= 1'b1;
               end
            end
            ST_DIV_END: begin
               hi    <= div_by_zero ? '0 : (neg_r ? (~div_r + 1'b1) : div_r);
               lo    <= div_by_zero ? '0 : (neg_q ? (~div_q + 1'b1) : div_q);
               state <= ST_IDLE;
            end
`ifdef MULT_ITER_EN
            ST_MUL_ON: begin
               if (annul) begin
                  state <= ST_IDLE;
               end else begin
                  if (mplier[0]) prod <= prod + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  mcnt   <= mcnt + CNT_W'(1);
                  if (mcnt == CNT_W'(DIV_CYCLES - 1)) begin
                     state <= ST_MUL_END;
                     ready <= 1'b1;
                  end
               end
            end
            ST_MUL_END: begin
               {hi, lo} <= neg_p ? (~prod + 1'b1) : prod;
               state    <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random ops
// checked against an arithmetic reference model of HI/LO and latency.
module tb_muldiv_ctrl;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_DIV   = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_MULT  = 3'd3;
   localparam logic [2:0] OP_MULTU = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        rst, start, annul;
   logic [2:0]  op;
   logic [31:0] src1, src2;
   logic        stallreq, ready, busy;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   muldiv_ctrl #(
      .DIV_CYCLES (32),
      .DATA_WD    (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .src1     (src1),
      .src2     (src2),
      .annul    (annul),
      .stallreq (stallreq),
      .ready    (ready),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model: {hi, lo} after an op, from plain integer arithmetic
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] cur_hi,
                                              input logic [31:0] cur_lo);
      longint          sa = $signed(a);
      longint          sb = $signed(b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint          q, r, p;
      longint unsigned uq, ur, up;
      logic [63:0]     res;
      res = {cur_hi, cur_lo};
      case (o)
         OP_DIV: begin
            if (b == 0) res = 64'd0;
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         OP_DIVU: begin
            if (b == 0) res = 64'd0;
            else begin
               uq = ua / ub;
               ur = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
         OP_MULT:  begin p = sa * sb;  res = p; end
         OP_MULTU: begin up = ua * ub; res = up; end
         OP_MTHI:  res = {a, cur_lo};
         OP_MTLO:  res = {cur_hi, a};
         default: ;
      endcase
      return res;
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
      if (o == OP_DIV || o == OP_DIVU) return (b == 0) ? 2 : 33;
`ifdef MULT_ITER_EN
      if (o == OP_MULT || o == OP_MULTU) return 33;
`endif
      return 1;
   endfunction

   function automatic int exp_stalls(input logic [2:0] o, input logic [31:0] b);
      if (o == OP_DIV || o == OP_DIVU) return (b == 0) ? 2 : 33;
`ifdef MULT_ITER_EN
      if (o == OP_MULT || o == OP_MULTU) return 33;
`endif
      return 0;
   endfunction

   // Issue one request as EX would: hold start while stalled, drop it otherwise.
   // Returns the cycle index of the ready pulse (-1 if none) and stalled cycles.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls);
      logic drop;
      lat = -1;
      stalls = 0;
      start = 1'b1; op = o; src1 = a; src2 = b;
      for (int t = 0; t <= 40; t++) begin
         @(negedge clk);
         if (stallreq) stalls++;
         if (ready) begin
            lat = t;
            break;
         end
         drop = !stallreq;
         @(posedge clk); #1;
         if (drop) begin start = 1'b0; op = OP_NONE; end
      end
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; annul = 1'b0; op = OP_NONE; src1 = '0; src2 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++; if (hi !== 32'd0)    begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
      tests++; if (lo !== 32'd0)    begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
      tests++; if (ready !== 1'b0)  begin fails++; $display("FAIL reset_ready got=%b exp=0", ready); end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stallreq); end
      tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_divu();
      int lat, stalls;
      do_op(OP_DIVU, 32'd100, 32'd7, lat, stalls);
      tests++; if (lat !== 33)    begin fails++; $display("FAIL divu_lat got=%0d exp=33", lat); end
      tests++; if (stalls !== 33) begin fails++; $display("FAIL divu_stalls got=%0d exp=33", stalls); end
      tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); end
      tests++; if (hi !== 32'd2)  begin fails++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); end
   endtask

   task automatic test_div_signed();
      int lat, stalls;
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, stalls);
      tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_lo got=%h exp=FFFFFFFD", lo); end
      tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_hi got=%h exp=FFFFFFFF", hi); end
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls);
      tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
      tests++; if (hi !== 32'd0)         begin fails++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, stalls);
      tests++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD})
         begin fails++; $display("FAIL div_pos_neg got=%h exp=00000001FFFFFFFD", {hi, lo}); end
   endtask

   task automatic test_div_zero();
      int lat, stalls;
      do_op(OP_MTHI, 32'hAAAA_0001, 32'd0, lat, stalls);
      do_op(OP_DIV, 32'd5, 32'd0, lat, stalls);
      tests++; if (lat !== 2)    begin fails++; $display("FAIL divz_lat got=%0d exp=2", lat); end
      tests++; if (stalls !== 2) begin fails++; $display("FAIL divz_stalls got=%0d exp=2", stalls); end
      tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL divz_hilo got=%h exp=0", {hi, lo}); end
   endtask

   task automatic test_mt();
      int lat, stalls;
      do_op(OP_MTHI, 32'h0000_1234, 32'hFFFF_FFFF, lat, stalls);
      tests++; if (lat !== 1)    begin fails++; $display("FAIL mthi_lat got=%0d exp=1", lat); end
      tests++; if (stalls !== 0) begin fails++; $display("FAIL mthi_stalls got=%0d exp=0", stalls); end
      do_op(OP_MTLO, 32'h0000_5678, 32'd0, lat, stalls);
      tests++; if ({hi, lo} !== {32'h1234, 32'h5678})
         begin fails++; $display("FAIL mt_hilo got=%h exp=0000123400005678", {hi, lo}); end
   endtask

   task automatic test_annul();
      int pulses;
      int lat, stalls;
      do_op(OP_MTHI, 32'h0000_1234, 32'd0, lat, stalls);
      do_op(OP_MTLO, 32'h0000_5678, 32'd0, lat, stalls);
      start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
      end
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0; start = 1'b0; op = OP_NONE;
      @(negedge clk);
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL annul_busy got=%b exp=0", busy); end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL annul_stall got=%b exp=0", stallreq); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL annul_ready got=%0d exp=0", pulses); end
      tests++; if ({hi, lo} !== {32'h1234, 32'h5678})
         begin fails++; $display("FAIL annul_hilo got=%h exp=0000123400005678", {hi, lo}); end
      // annul alongside a fresh request in IDLE drops it
      @(posedge clk); #1;
      start = 1'b1; annul = 1'b1; op = OP_MTHI; src1 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0; op = OP_NONE;
      @(negedge clk);
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL idle_annul_ready got=%b exp=0", ready); end
      tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL idle_annul_hi got=%h exp=00001234", hi); end
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int lat, stalls;
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, stalls);
      tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1)
         begin fails++; $display("FAIL mult_neg got=%h exp=FFFFFFFFFFFFFFF1", {hi, lo}); end
      tests++; if (lat !== exp_lat(OP_MULT, 32'd5))
         begin fails++; $display("FAIL mult_lat got=%0d exp=%0d", lat, exp_lat(OP_MULT, 32'd5)); end
      tests++; if (stalls !== exp_stalls(OP_MULT, 32'd5))
         begin fails++; $display("FAIL mult_stalls got=%0d exp=%0d", stalls, exp_stalls(OP_MULT, 32'd5)); end
      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls);
      tests++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
         begin fails++; $display("FAIL multu_max got=%h exp=FFFFFFFE00000001", {hi, lo}); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      lat = -1;
      start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
      @(posedge clk); #1;
      op = OP_MTHI; src1 = 32'h0000_1234;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (ready) begin lat = t; break; end
         @(posedge clk); #1;
      end
      tests++; if (lat !== 33) begin fails++; $display("FAIL ignore_lat got=%0d exp=33", lat); end
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if ({hi, lo} !== {32'd2, 32'd14})
         begin fails++; $display("FAIL ignore_div got=%h exp=000000020000000E", {hi, lo}); end
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      @(negedge clk);
      tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL reissue_mthi got=%h exp=00001234", hi); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; op = OP_NONE;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL rstmid_hilo got=%h exp=0", {hi, lo}); end
      tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL rstmid_stall got=%b exp=0", stallreq); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [31:0] mhi, mlo, a, b;
      logic [2:0]  o;
      logic [63:0] exp;
      int          lat, stalls;
      do_op(OP_MTHI, 32'h0BAD_F00D, 32'd0, lat, stalls);
      do_op(OP_MTLO, 32'h1357_9BDF, 32'd0, lat, stalls);
      mhi = 32'h0BAD_F00D;
      mlo = 32'h1357_9BDF;
      for (int n = 0; n < 40; n++) begin
         o = 3'($urandom_range(1, 6));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         exp = ref_result(o, a, b, mhi, mlo);
         do_op(o, a, b, lat, stalls);
         tests++;
         if ({hi, lo} !== exp)
            begin fails++; $display("FAIL rand_hilo op=%0d a=%h b=%h got=%h exp=%h", o, a, b, {hi, lo}, exp); end
         tests++;
         if (lat !== exp_lat(o, b))
            begin fails++; $display("FAIL rand_lat op=%0d got=%0d exp=%0d", o, lat, exp_lat(o, b)); end
         tests++;
         if (stalls !== exp_stalls(o, b))
            begin fails++; $display("FAIL rand_stalls op=%0d got=%0d exp=%0d", o, stalls, exp_stalls(o, b)); end
         {mhi, mlo} = exp;
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_mt();
      test_annul();
      test_mult();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
